muldiv_sequencer: RTL

- Multi-cycle multiply/divide controller beside the EX stage ALU. Executes MULT/MULTU/DIV/DIVU on EX operands and owns the HI/LO registers.
- Runs iterative shift-add (multiply) or restoring shift-subtract (divide), one bit per cycle.
- Drives a stall request to the hazard logic so IF/ID/EX hold until the result is in HI/LO.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_datapath.sv | 88 ++++++++
 rtl/muldiv_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath, one bit per step, with final sign fix.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opb;
    logic               is_div, neg_q, neg_r;

    logic               signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fixed;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = signed_op & src_a[WIDTH-1];
        sign_b    = signed_op & src_b[WIDTH-1];
        mag_a     = sign_a ? -src_a : src_a;
        mag_b     = sign_b ? -src_b : src_b;
    end

    always_comb begin
        acc_next  = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        // Compare at WIDTH+1 bits so a divisor with its MSB set is handled.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];
        if (is_div) begin
            acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load) begin
            is_div <= op[1];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            if (op[1]) begin
                acc <= {{WIDTH{1'b0}}, mag_a};
                opb <= mag_b;
            end else begin
                acc <= {{WIDTH{1'b0}}, mag_b};
                opb <= mag_a;
            end
        end else if (step) begin
            acc <= acc_next;
        end
    end

    always_comb begin
        prod_fixed = neg_q ? -acc : acc;
        if (is_div) begin
            res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fixed[WIDTH-1:0];
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV controller: FSM, iteration counter, pipeline stall and HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic             accept, is_div, zero_div;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        accept   = (state == StIdle) && start && !flush;
        is_div   = (op == OP_DIVU) || (op == OP_DIV);
        zero_div = is_div && (src_b == '0);
        stall    = accept || (state == StCalc) || (state == StFix);
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && !zero_div),
        .step   (state == StCalc),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if ((state == StIdle) || (state == StDone)) begin
                if (mt_hi) hi <= mt_data;
                if (mt_lo) lo <= mt_data;
            end
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        // Div-by-zero result overrides a same-cycle MT write.
                        if (zero_div) begin
                            state       <= StDone;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi          <= src_a;
                            lo          <= '1;
                        end else begin
                            state <= StCalc;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (cnt == LastCnt) begin
                        state <= StFix;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFix: begin
                    state <= flush ? StIdle : StDone;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
